mem_stage: RTL and testbench

Memory-access stage directly downstream of the execute stage. It consumes the EX/MEM pipeline register contents: ALU result, store data, destination register and memory enables. It performs load/store transactions on a req/gnt/rvalid data bus and owns the MEM/WB pipeline register. That register supplies the `mem_wb_*` write-back and forwarding operands used by EX. While a bus transaction is outstanding, the stage stalls the front of the pipeline.

---
 rtl/mem_stage_pkg.sv | 41 ++++
 rtl/mem_stage_lsu_align.sv | 42 ++++
 rtl/mem_stage.sv | 125 ++++++++++++
 tb/tb_mem_stage.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, funct3 codes, FSM states and access-size helpers for the memory stage.
package mem_stage_pkg;

    localparam int REG      = 32;
    localparam int REG_ADDR = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10
    } mem_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } access_size_e;

    // Unused codes 011/110/111 fall through to word accesses.
    function automatic access_size_e access_size(input logic [2:0] funct3);
        case (funct3)
            F3_LB, F3_LBU: return SZ_BYTE;
            F3_LH, F3_LHU: return SZ_HALF;
            default:       return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (access_size(funct3))
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering: store byte enables / replicated write data and load lane extraction.
module lsu_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]     addr_lo,
    input  logic [2:0]     funct3,
    input  logic [REG-1:0] store_data,
    input  logic [REG-1:0] read_word,
    output logic [3:0]     be,
    output logic [REG-1:0] wdata,
    output logic [REG-1:0] load_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sign_ext;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        be        = 4'b1111;
        wdata     = store_data;
        load_data = read_word;
        byte_lane = read_word[{addr_lo, 3'b000} +: 8];
        half_lane = addr_lo[1] ? read_word[31:16] : read_word[15:0];
        sign_ext  = (funct3 == F3_LB) || (funct3 == F3_LH);

        case (access_size(funct3))
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            end
            SZ_HALF: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata     = {2{store_data[15:0]}};
                load_data = {{16{sign_ext & half_lane[15]}}, half_lane};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: req/gnt/rvalid data-bus master plus the MEM/WB pipeline register.
// Optional macro MEM_MISALIGN_TRAP_EN turns misaligned accesses into bus-free bubbles with a misalign_o pulse.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ex_mem_valid_i,
    input  logic                ex_mem_mem_r_ena_i,
    input  logic                ex_mem_mem_w_ena_i,
    input  logic [2:0]          ex_mem_funct3_i,
    input  logic [REG-1:0]      ex_mem_alu_result_i,
    input  logic [REG-1:0]      ex_mem_reg2_r_data_i,
    input  logic [REG_ADDR-1:0] ex_mem_reg_w_addr_i,
    input  logic                ex_mem_reg_w_ena_i,
    output logic                dbus_req_o,
    output logic                dbus_we_o,
    output logic [REG-1:0]      dbus_addr_o,
    output logic [3:0]          dbus_be_o,
    output logic [REG-1:0]      dbus_wdata_o,
    input  logic                dbus_gnt_i,
    input  logic                dbus_rvalid_i,
    input  logic [REG-1:0]      dbus_rdata_i,
    output logic                mem_hold_o,
    output logic [REG_ADDR-1:0] mem_wb_reg_w_addr_o,
    output logic [REG-1:0]      mem_wb_reg_w_data_o,
    output logic                mem_wb_reg_w_ena_o,
    output logic                misalign_o
);

    mem_state_e     state;
    logic [1:0]     addr_lo_q;
    logic [2:0]     funct3_q;
    logic           mem_op, trap, start, complete, load_done;
    logic [1:0]     sel_lo;
    logic [2:0]     sel_funct3;
    logic [3:0]     be_c;
    logic [REG-1:0] wdata_c, load_data_c;

    assign mem_op = ex_mem_valid_i & (ex_mem_mem_r_ena_i | ex_mem_mem_w_ena_i);

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = (state == ST_IDLE) & mem_op
                & is_misaligned(ex_mem_funct3_i, ex_mem_alu_result_i[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign start      = (state == ST_IDLE) & mem_op & ~trap;
    assign load_done  = (state == ST_WAIT) & dbus_rvalid_i;
    assign complete   = ((state == ST_REQ) & dbus_gnt_i & dbus_we_o) | load_done;
    assign mem_hold_o = mem_op & ~complete & ~trap;

    // Incoming op steers the lanes while idle; the captured op owns them once on the bus.
    assign sel_lo     = (state == ST_IDLE) ? ex_mem_alu_result_i[1:0] : addr_lo_q;
    assign sel_funct3 = (state == ST_IDLE) ? ex_mem_funct3_i : funct3_q;

    lsu_align u_lsu_align (
        .addr_lo    (sel_lo),
        .funct3     (sel_funct3),
        .store_data (ex_mem_reg2_r_data_i),
        .read_word  (dbus_rdata_i),
        .be         (be_c),
        .wdata      (wdata_c),
        .load_data  (load_data_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            dbus_req_o   <= 1'b0;
            dbus_we_o    <= 1'b0;
            dbus_addr_o  <= '0;
            dbus_be_o    <= '0;
            dbus_wdata_o <= '0;
            addr_lo_q    <= '0;
            funct3_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            case (state)
                ST_IDLE: if (start) begin
                    state        <= ST_REQ;
                    dbus_req_o   <= 1'b1;
                    dbus_we_o    <= ex_mem_mem_w_ena_i & ~ex_mem_mem_r_ena_i;
                    dbus_addr_o  <= {ex_mem_alu_result_i[REG-1:2], 2'b00};
                    dbus_be_o    <= be_c;
                    dbus_wdata_o <= wdata_c;
                    addr_lo_q    <= ex_mem_alu_result_i[1:0];
                    funct3_q     <= ex_mem_funct3_i;
                end
                ST_REQ: if (dbus_gnt_i) begin
                    dbus_req_o <= 1'b0;
                    state      <= dbus_we_o ? ST_IDLE : ST_WAIT;
                end
                ST_WAIT: if (dbus_rvalid_i) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: MEM/WB is reset because EX forwards from it before the first real write-back.
            mem_wb_reg_w_addr_o <= '0;
            mem_wb_reg_w_data_o <= '0;
            mem_wb_reg_w_ena_o  <= 1'b0;
        end else if (mem_hold_o || trap) begin
            mem_wb_reg_w_ena_o  <= 1'b0;
        end else begin
            mem_wb_reg_w_addr_o <= ex_mem_reg_w_addr_i;
            mem_wb_reg_w_ena_o  <= ex_mem_reg_w_ena_i & ex_mem_valid_i;
            mem_wb_reg_w_data_o <= load_done ? load_data_c : ex_mem_alu_result_i;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_o <= 1'b0;
        else        misalign_o <= trap;
    end
`else
    assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized ops against an arithmetic lane model.
module tb_mem_stage;

    logic        clk, rst_n;
    logic        ex_mem_valid_i, ex_mem_mem_r_ena_i, ex_mem_mem_w_ena_i;
    logic [2:0]  ex_mem_funct3_i;
    logic [31:0] ex_mem_alu_result_i, ex_mem_reg2_r_data_i;
    logic [4:0]  ex_mem_reg_w_addr_i;
    logic        ex_mem_reg_w_ena_i;
    logic        dbus_req_o, dbus_we_o;
    logic [31:0] dbus_addr_o, dbus_wdata_o;
    logic [3:0]  dbus_be_o;
    logic        dbus_gnt_i, dbus_rvalid_i;
    logic [31:0] dbus_rdata_i;
    logic        mem_hold_o;
    logic [4:0]  mem_wb_reg_w_addr_o;
    logic [31:0] mem_wb_reg_w_data_o;
    logic        mem_wb_reg_w_ena_o;
    logic        misalign_o;

    int errors = 0;
    int checks = 0;

    mem_stage dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .ex_mem_valid_i       (ex_mem_valid_i),
        .ex_mem_mem_r_ena_i   (ex_mem_mem_r_ena_i),
        .ex_mem_mem_w_ena_i   (ex_mem_mem_w_ena_i),
        .ex_mem_funct3_i      (ex_mem_funct3_i),
        .ex_mem_alu_result_i  (ex_mem_alu_result_i),
        .ex_mem_reg2_r_data_i (ex_mem_reg2_r_data_i),
        .ex_mem_reg_w_addr_i  (ex_mem_reg_w_addr_i),
        .ex_mem_reg_w_ena_i   (ex_mem_reg_w_ena_i),
        .dbus_req_o           (dbus_req_o),
        .dbus_we_o            (dbus_we_o),
        .dbus_addr_o          (dbus_addr_o),
        .dbus_be_o            (dbus_be_o),
        .dbus_wdata_o         (dbus_wdata_o),
        .dbus_gnt_i           (dbus_gnt_i),
        .dbus_rvalid_i        (dbus_rvalid_i),
        .dbus_rdata_i         (dbus_rdata_i),
        .mem_hold_o           (mem_hold_o),
        .mem_wb_reg_w_addr_o  (mem_wb_reg_w_addr_o),
        .mem_wb_reg_w_data_o  (mem_wb_reg_w_data_o),
        .mem_wb_reg_w_ena_o   (mem_wb_reg_w_ena_o),
        .misalign_o           (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: access size in bytes, offset rounded down to that size.
    function automatic int ref_size(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic int ref_offset(input logic [2:0] f3, input logic [31:0] a);
        int sz = ref_size(f3);
        return (int'(a % 4) / sz) * sz;
    endfunction

    function automatic logic ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
        return (a % ref_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        int sz = ref_size(f3);
        return 4'(((1 << sz) - 1) << ref_offset(f3, a));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        int sz = ref_size(f3);
        if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        int sz = ref_size(f3);
        logic [31:0] mask, val;
        if (sz == 4) return w;
        mask = (32'd1 << (8 * sz)) - 32'd1;
        val  = (w >> (8 * ref_offset(f3, a))) & mask;
        if ((f3 == 3'b000 || f3 == 3'b001) && val[8 * sz - 1]) val = val | ~mask;
        return val;
    endfunction

    // Drives one memory op with a responsive slave; reports what the bus and hold looked like.
    task automatic run_mem_op(
        input  logic        r, input logic w, input logic [2:0] f3,
        input  logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
        input  logic [4:0]  rd, input logic rd_en, input int gnt_dly, input int rv_dly,
        output int          hold_cnt, output logic [31:0] o_addr, output logic [3:0] o_be,
        output logic [31:0] o_wdata, output logic o_we, output logic stable,
        output logic        bubble_ok, output logic timed_out
    );
        int   req_cycles, wait_cycles;
        logic granted, done, seen_req;
        hold_cnt = 0; stable = 1'b1; bubble_ok = 1'b1; timed_out = 1'b1;
        granted = 1'b0; done = 1'b0; seen_req = 1'b0; req_cycles = 0; wait_cycles = 0;
        o_addr = '0; o_be = '0; o_wdata = '0; o_we = 1'b0;
        @(negedge clk);
        ex_mem_valid_i = 1'b1; ex_mem_mem_r_ena_i = r; ex_mem_mem_w_ena_i = w;
        ex_mem_funct3_i = f3; ex_mem_alu_result_i = addr; ex_mem_reg2_r_data_i = sdata;
        ex_mem_reg_w_addr_i = rd; ex_mem_reg_w_ena_i = rd_en;
        dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            #1;
            if (dbus_req_o) begin
                if (!seen_req) begin
                    o_addr = dbus_addr_o; o_be = dbus_be_o; o_wdata = dbus_wdata_o; o_we = dbus_we_o;
                    seen_req = 1'b1;
                end else if (dbus_addr_o !== o_addr || dbus_be_o !== o_be ||
                             dbus_wdata_o !== o_wdata || dbus_we_o !== o_we) begin
                    stable = 1'b0;
                end
                dbus_gnt_i = (req_cycles == gnt_dly);
                req_cycles++;
            end else if (granted) begin
                wait_cycles++;
                dbus_rvalid_i = (wait_cycles == rv_dly);
                dbus_rdata_i  = dbus_rvalid_i ? rdata : $urandom;
            end
            #1;
            if (mem_hold_o) hold_cnt++;
            else begin done = 1'b1; timed_out = 1'b0; end
            if (dbus_gnt_i) granted = 1'b1;
            @(negedge clk);
            if (!done && mem_wb_reg_w_ena_o !== 1'b0) bubble_ok = 1'b0;
            dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0;
        end
        ex_mem_valid_i = 1'b0; ex_mem_mem_r_ena_i = 1'b0; ex_mem_mem_w_ena_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ex_mem_valid_i = 0; ex_mem_mem_r_ena_i = 0; ex_mem_mem_w_ena_i = 0; ex_mem_funct3_i = 0;
        ex_mem_alu_result_i = 0; ex_mem_reg2_r_data_i = 0; ex_mem_reg_w_addr_i = 0; ex_mem_reg_w_ena_i = 0;
        dbus_gnt_i = 0; dbus_rvalid_i = 0; dbus_rdata_i = 0;
        #12;
        checks++;
        if ({dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o} !== '0) begin
            errors++;
            $display("FAIL reset_bus: req=%b we=%b addr=%h be=%b wdata=%h expected all 0",
                     dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o);
        end
        checks++;
        if ({mem_wb_reg_w_addr_o, mem_wb_reg_w_data_o, mem_wb_reg_w_ena_o, misalign_o, mem_hold_o} !== '0) begin
            errors++;
            $display("FAIL reset_wb: addr=%h data=%h ena=%b misalign=%b hold=%b expected all 0",
                     mem_wb_reg_w_addr_o, mem_wb_reg_w_data_o, mem_wb_reg_w_ena_o, misalign_o, mem_hold_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alu(input logic [4:0] rd, input logic [31:0] result);
        @(negedge clk);
        ex_mem_valid_i = 1'b1; ex_mem_mem_r_ena_i = 1'b0; ex_mem_mem_w_ena_i = 1'b0;
        ex_mem_funct3_i = 3'($urandom); ex_mem_alu_result_i = result; ex_mem_reg2_r_data_i = $urandom;
        ex_mem_reg_w_addr_i = rd; ex_mem_reg_w_ena_i = 1'b1;
        dbus_rvalid_i = 1'b1; dbus_rdata_i = $urandom;   // stray rvalid outside WAIT must be ignored
        #1;
        checks++;
        if (mem_hold_o !== 1'b0 || dbus_req_o !== 1'b0) begin
            errors++;
            $display("FAIL alu_hold: hold=%b req=%b expected 0 0", mem_hold_o, dbus_req_o);
        end
        @(negedge clk);
        ex_mem_valid_i = 1'b0; dbus_rvalid_i = 1'b0;
        checks++;
        if ({mem_wb_reg_w_addr_o, mem_wb_reg_w_data_o, mem_wb_reg_w_ena_o} !== {rd, result, 1'b1}) begin
            errors++;
            $display("FAIL alu_wb: rd=%0d data=%h ena=%b expected rd=%0d data=%h ena=1",
                     mem_wb_reg_w_addr_o, mem_wb_reg_w_data_o, mem_wb_reg_w_ena_o, rd, result);
        end
    endtask

    // Directed or random memory op; all expectations come from the reference functions above.
    task automatic test_mem_op(input string name, input logic r, input logic w, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                               input logic [4:0] rd, input logic rd_en, input int gnt_dly, input int rv_dly);
        int          hold_cnt, exp_hold;
        logic [31:0] o_addr, o_wdata, exp_data;
        logic [3:0]  o_be;
        logic        o_we, stable, bubble_ok, timed_out, is_load;
        run_mem_op(r, w, f3, addr, sdata, rdata, rd, rd_en, gnt_dly, rv_dly,
                   hold_cnt, o_addr, o_be, o_wdata, o_we, stable, bubble_ok, timed_out);
        is_load  = r;
        exp_hold = is_load ? gnt_dly + 1 + rv_dly : gnt_dly + 1;
        exp_data = is_load ? ref_load(f3, addr, rdata) : addr;
        checks++;
        if (timed_out || hold_cnt != exp_hold) begin
            errors++;
            $display("FAIL %s_hold: hold_cycles=%0d timeout=%b expected %0d", name, hold_cnt, timed_out, exp_hold);
        end
        checks++;
        if (o_addr !== (addr & 32'hFFFF_FFFC) || o_we !== !is_load || !stable) begin
            errors++;
            $display("FAIL %s_req: addr=%h we=%b stable=%b expected addr=%h we=%b stable=1",
                     name, o_addr, o_we, stable, addr & 32'hFFFF_FFFC, !is_load);
        end
        if (!is_load) begin
            checks++;
            if (o_be !== ref_be(f3, addr) || o_wdata !== ref_wdata(f3, sdata)) begin
                errors++;
                $display("FAIL %s_lanes: be=%b wdata=%h expected be=%b wdata=%h",
                         name, o_be, o_wdata, ref_be(f3, addr), ref_wdata(f3, sdata));
            end
        end
        checks++;
        if (!bubble_ok || {mem_wb_reg_w_addr_o, mem_wb_reg_w_data_o, mem_wb_reg_w_ena_o} !== {rd, exp_data, rd_en}) begin
            errors++;
            $display("FAIL %s_wb: rd=%0d data=%h ena=%b bubbles_ok=%b expected rd=%0d data=%h ena=%b",
                     name, mem_wb_reg_w_addr_o, mem_wb_reg_w_data_o, mem_wb_reg_w_ena_o, bubble_ok,
                     rd, exp_data, rd_en);
        end
    endtask

    task automatic test_misalign;
`ifdef MEM_MISALIGN_TRAP_EN
        logic [2:0]  f3s [3]  = '{3'b010, 3'b001, 3'b010};
        logic [31:0] adrs [3] = '{32'h3002, 32'h3005, 32'h3001};
        logic        wrs [3]  = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ex_mem_valid_i = 1'b1; ex_mem_mem_r_ena_i = !wrs[i]; ex_mem_mem_w_ena_i = wrs[i];
            ex_mem_funct3_i = f3s[i]; ex_mem_alu_result_i = adrs[i]; ex_mem_reg2_r_data_i = $urandom;
            ex_mem_reg_w_addr_i = 5'd4; ex_mem_reg_w_ena_i = 1'b1;
            #1;
            checks++;
            if (mem_hold_o !== 1'b0 || dbus_req_o !== 1'b0) begin
                errors++;
                $display("FAIL misalign_hold[%0d]: hold=%b req=%b expected 0 0", i, mem_hold_o, dbus_req_o);
            end
            @(negedge clk);
            ex_mem_valid_i = 1'b0;
            checks++;
            if (misalign_o !== 1'b1 || mem_wb_reg_w_ena_o !== 1'b0 || dbus_req_o !== 1'b0) begin
                errors++;
                $display("FAIL misalign_pulse[%0d]: misalign=%b ena=%b req=%b expected 1 0 0",
                         i, misalign_o, mem_wb_reg_w_ena_o, dbus_req_o);
            end
            @(negedge clk);
            checks++;
            if (misalign_o !== 1'b0) begin
                errors++;
                $display("FAIL misalign_clear[%0d]: misalign=%b expected 0", i, misalign_o);
            end
        end
`else
        test_mem_op("lw_unaligned", 1'b1, 1'b0, 3'b010, 32'h3002, 32'h0, 32'hCAFE_F00D, 5'd4, 1'b1, 0, 1);
        checks++;
        if (misalign_o !== 1'b0) begin
            errors++;
            $display("FAIL misalign_tied: misalign=%b expected 0", misalign_o);
        end
`endif
    endtask

    task automatic test_reset_mid;
        test_alu(5'd11, 32'h5A5A_0001);
        @(negedge clk);
        ex_mem_valid_i = 1'b1; ex_mem_mem_r_ena_i = 1'b1; ex_mem_mem_w_ena_i = 1'b0;
        ex_mem_funct3_i = 3'b010; ex_mem_alu_result_i = 32'h4000; ex_mem_reg_w_addr_i = 5'd3;
        ex_mem_reg_w_ena_i = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (dbus_req_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_req: req=%b expected 1", dbus_req_o);
        end
        dbus_gnt_i = 1'b1;
        @(negedge clk);
        dbus_gnt_i = 1'b0;
        #2;
        rst_n = 1'b0;
        ex_mem_valid_i = 1'b0; ex_mem_mem_r_ena_i = 1'b0;
        #1;
        checks++;
        if ({dbus_req_o, mem_hold_o, mem_wb_reg_w_addr_o, mem_wb_reg_w_data_o, mem_wb_reg_w_ena_o} !== '0) begin
            errors++;
            $display("FAIL rstmid_clear: req=%b hold=%b rd=%0d data=%h ena=%b expected all 0",
                     dbus_req_o, mem_hold_o, mem_wb_reg_w_addr_o, mem_wb_reg_w_data_o, mem_wb_reg_w_ena_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_mem_op("lw_after_rst", 1'b1, 1'b0, 3'b010, 32'h4008, 32'h0, 32'h1357_9BDF, 5'd3, 1'b1, 1, 2);
    endtask

    task automatic test_random(input int n);
        logic [2:0]  f3;
        logic [31:0] addr;
        logic        is_load;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                test_alu(5'($urandom), $urandom);
            end else begin
                f3 = 3'($urandom);
                addr = $urandom;
`ifdef MEM_MISALIGN_TRAP_EN
                if (ref_misaligned(f3, addr)) addr = addr & 32'hFFFF_FFFC;
`endif
                is_load = $urandom_range(0, 1) != 0;
                test_mem_op(is_load ? "rnd_load" : "rnd_store", is_load,
                            is_load ? ($urandom_range(0, 1) != 0) : 1'b1,
                            f3, addr, $urandom, $urandom, 5'($urandom), ($urandom_range(0, 1) != 0),
                            $urandom_range(0, 3), $urandom_range(1, 3));
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu(5'd5, 32'h0000_1234);
        test_mem_op("sb", 1'b0, 1'b1, 3'b000, 32'h1003, 32'hAABB_CCDD, 32'h0, 5'd0, 1'b0, 0, 1);
        test_mem_op("lb", 1'b1, 1'b0, 3'b000, 32'h2001, 32'h0, 32'h0000_8000, 5'd7, 1'b1, 2, 3);
        test_mem_op("lhu", 1'b1, 1'b0, 3'b101, 32'h2002, 32'h0, 32'hBEEF_0000, 5'd9, 1'b1, 0, 1);
        test_mem_op("sh", 1'b0, 1'b1, 3'b001, 32'h2006, 32'h1234_5678, 32'h0, 5'd0, 1'b0, 1, 1);
        test_mem_op("both_en", 1'b1, 1'b1, 3'b001, 32'h2002, 32'h0, 32'h8001_0000, 5'd12, 1'b1, 0, 2);
        test_misalign();
        test_reset_mid();
        test_random(40);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
